// File: rtl/drbg_line_consumer.sv
// -----------------------------------------------------------------------------
// drbg_line_consumer
//
// Width converter between the hash-DRBG and the line rotator. Wide random
// blocks from the DRBG are split into narrow words, LSB word first. One new
// word is presented per video line (rising edge of H) as the rotator's cut
// position. One block can be prefetched behind the current one, and every
// frame start (rising edge of V) flushes all stored bits so the word sequence
// stays aligned with the DRBG reseed.
//
// Ports:
//   clk             rising-edge clock
//   reset_n         asynchronous active-low reset
//   H, V            horizontal / vertical blanking flags from the sync parser
//   data_in         random block from the DRBG
//   data_in_valid   one-cycle strobe qualifying data_in
//   generator_busy  DRBG busy; requests are deferred while high
//   data_out        current word (cut position)
//   data_out_valid  data_out holds a word of the current block
//   need_next       one-cycle request pulse for a new block
//
// Request/response handshake: need_next pulses for one cycle and marks a
// request outstanding; the next data_in_valid strobe while a request is
// outstanding delivers the block and retires the request. A strobe with no
// request outstanding is ignored, so at most one block is ever in flight and
// stale responses (after a flush or reset) are dropped.
// -----------------------------------------------------------------------------
module drbg_line_consumer #(
  parameter int DATA_WIDTH_IN  = 256,
  parameter int DATA_WIDTH_OUT = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      H,
  input  logic                      V,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      data_in_valid,
  input  logic                      generator_busy,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      data_out_valid,
  output logic                      need_next
);

  localparam int NWORDS = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  logic [DATA_WIDTH_IN-1:0]  cur_q, cur_d;
  logic [DATA_WIDTH_IN-1:0]  pend_q, pend_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      cur_valid_q, cur_valid_d;
  logic                      pend_valid_q, pend_valid_d;
  logic                      outstanding_q, outstanding_d;
  logic                      need_next_q, need_next_d;
  logic                      h_d_q, h_d_d;
  logic                      v_d_q, v_d_d;
  logic [DATA_WIDTH_OUT-1:0] data_out_q, data_out_d;

  logic h_rise;
  logic v_rise;
  logic req;

  always_comb begin
    cur_d         = cur_q;
    pend_d        = pend_q;
    idx_d         = idx_q;
    cur_valid_d   = cur_valid_q;
    pend_valid_d  = pend_valid_q;
    outstanding_d = outstanding_q;
    need_next_d   = 1'b0;
    h_d_d         = H;
    v_d_d         = V;
    data_out_d    = data_out_q;

    h_rise = H & ~h_d_q;
    v_rise = V & ~v_d_q;

    // Request when nothing is stored, or when the last word of the current
    // block is showing with no block queued behind it.
    req = ~generator_busy & ~outstanding_q & ~need_next_q &
          (~cur_valid_q | (~pend_valid_q & (idx_q == LAST_IDX)));

    if (v_rise) begin
      // Frame flush wins over advance and load; a block arriving now is lost.
      cur_valid_d   = 1'b0;
      pend_valid_d  = 1'b0;
      outstanding_d = 1'b0;
      idx_d         = '0;
    end else begin
      if (h_rise && cur_valid_q) begin
        if (idx_q != LAST_IDX) begin
          idx_d = idx_q + IDX_W'(1);
        end else if (pend_valid_q) begin
          cur_d        = pend_q;
          idx_d        = '0;
          pend_valid_d = 1'b0;
        end else begin
          cur_valid_d = 1'b0;
        end
      end

      // Load decision looks at the post-advance cur_valid so that a block
      // arriving in the same cycle the last word is retired goes straight
      // into cur instead of stranding in pend behind an empty cur.
      if (data_in_valid && outstanding_q) begin
        outstanding_d = 1'b0;
        if (!cur_valid_d) begin
          cur_d       = data_in;
          idx_d       = '0;
          cur_valid_d = 1'b1;
        end else begin
          pend_d       = data_in;
          pend_valid_d = 1'b1;
        end
      end

      // req requires no outstanding request, so it never coincides with a load.
      if (req) begin
        need_next_d   = 1'b1;
        outstanding_d = 1'b1;
      end
    end

    // Registered word select; holds the last word when cur goes invalid.
    if (cur_valid_d) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          data_out_d = cur_d[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_q         <= '0;
      pend_q        <= '0;
      idx_q         <= '0;
      cur_valid_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      outstanding_q <= 1'b0;
      need_next_q   <= 1'b0;
      h_d_q         <= 1'b0;
      v_d_q         <= 1'b0;
      data_out_q    <= '0;
    end else begin
      cur_q         <= cur_d;
      pend_q        <= pend_d;
      idx_q         <= idx_d;
      cur_valid_q   <= cur_valid_d;
      pend_valid_q  <= pend_valid_d;
      outstanding_q <= outstanding_d;
      need_next_q   <= need_next_d;
      h_d_q         <= h_d_d;
      v_d_q         <= v_d_d;
      data_out_q    <= data_out_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = cur_valid_q;
  assign need_next      = need_next_q;

endmodule

// File: tb/tb_drbg_line_consumer.sv
// -----------------------------------------------------------------------------
// tb_drbg_line_consumer
//
// Drives drbg_line_consumer with directed and random line/frame/DRBG traffic.
// The reference model treats storage as one FIFO of words: the head is the
// word on data_out, a block load appends all its words, a line edge pops the
// head, a frame edge empties it. A request is due when at most one word
// remains. Expected outputs are queued per clock and checked by a monitor on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_drbg_line_consumer;

  localparam int WI = 256;
  localparam int WO = 8;
  localparam int NW = WI / WO;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          h = 1'b0;
  logic          v = 1'b0;
  logic [WI-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          generator_busy = 1'b1;
  logic [WO-1:0] data_out;
  logic          data_out_valid;
  logic          need_next;

  always #5 clk = ~clk;

  drbg_line_consumer #(
    .DATA_WIDTH_IN (WI),
    .DATA_WIDTH_OUT(WO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .H             (h),
    .V             (v),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .generator_busy(generator_busy),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .need_next     (need_next)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [WO+1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic [WO-1:0] m_words[$];
  bit            m_need;
  bit            m_outst;
  bit            m_hd;
  bit            m_vd;
  logic [WO-1:0] m_last;

  // DRBG emulator
  bit            auto_resp = 1'b0;
  int            resp_lat  = 1;
  int            pend_resp = -1;
  logic [WI-1:0] next_block;

  function automatic logic [WI-1:0] rand_block();
    logic [WI-1:0] b;
    for (int i = 0; i < WI / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  function automatic logic [WI-1:0] count_block();
    logic [WI-1:0] b;
    for (int k = 0; k < NW; k++) b[k*WO +: WO] = WO'(k);
    return b;
  endfunction

  task automatic model_reset();
    m_words.delete();
    m_need  = 1'b0;
    m_outst = 1'b0;
    m_hd    = 1'b0;
    m_vd    = 1'b0;
    m_last  = '0;
  endtask

  task automatic model_cycle(input bit hh, input bit vv, input bit dv,
                             input bit busy, input logic [WI-1:0] din);
    bit h_rise;
    bit v_rise;
    bit req;
    h_rise = hh && !m_hd;
    v_rise = vv && !m_vd;
    if (v_rise) begin
      m_words.delete();
      m_outst = 1'b0;
      m_need  = 1'b0;
    end else begin
      req = !busy && !m_outst && !m_need && (m_words.size() <= 1);
      if (h_rise && m_words.size() > 0) void'(m_words.pop_front());
      if (dv && m_outst) begin
        for (int k = 0; k < NW; k++) m_words.push_back(din[k*WO +: WO]);
        m_outst = 1'b0;
      end
      if (req) m_outst = 1'b1;
      m_need = req;
    end
    if (m_words.size() > 0) m_last = m_words[0];
    m_hd = hh;
    m_vd = vv;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit hh, input bit vv, input bit dv,
                      input bit busy, input logic [WI-1:0] din);
    h              = hh;
    v              = vv;
    data_in_valid  = dv;
    generator_busy = busy;
    data_in        = din;
    model_cycle(hh, vv, dv, busy, din);
    @(posedge clk);
    exp_q.push_back({(m_words.size() > 0), m_last, m_need});
    #1;
  endtask

  task automatic run_cycle(input bit hh, input bit vv, input bit busy);
    bit            dv;
    logic [WI-1:0] din;
    dv  = 1'b0;
    din = '0;
    if (pend_resp == 0) begin
      dv         = 1'b1;
      din        = next_block;
      next_block = rand_block();
      pend_resp  = -1;
    end else if (pend_resp > 0) begin
      pend_resp--;
    end
    step(hh, vv, dv, busy, din);
    if (m_need && auto_resp) pend_resp = resp_lat;
  endtask

  task automatic h_pulse(input bit busy);
    run_cycle(1'b1, 1'b0, busy);
    run_cycle(1'b0, 1'b0, busy);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, away from both clock edges.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n        = 1'b0;
    h              = 1'b0;
    v              = 1'b0;
    data_in_valid  = 1'b0;
    generator_busy = 1'b1;
    #1;
    check("async_rst_data_out", 32'(data_out), 32'h0);
    check("async_rst_valid", 32'(data_out_valid), 32'h0);
    check("async_rst_need", 32'(need_next), 32'h0);
    model_reset();
    pend_resp = -1;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [WO+1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({data_out_valid, data_out, need_next} !== e) begin
        bad++;
        $display("FAIL out_cmp at %0t: got valid=%0b data=%02h need=%0b expected valid=%0b data=%02h need=%0b",
                 $time, data_out_valid, data_out, need_next, e[WO+1], e[WO:1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit hl;
    bit vl;
    model_reset();
    next_block = count_block();

    // Reset state
    #12;
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_valid", 32'(data_out_valid), 32'h0);
    check("reset_need", 32'(need_next), 32'h0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;

    // First request and counting-block load
    auto_resp = 1'b1;
    resp_lat  = 1;
    repeat (6) run_cycle(1'b0, 1'b0, 1'b0);

    // Step through the block; prefetch requested at the last word
    repeat (31) h_pulse(1'b0);
    repeat (5) run_cycle(1'b0, 1'b0, 1'b0);
    repeat (4) h_pulse(1'b0);

    // Starvation: no responses, block runs dry, data_out holds
    auto_resp = 1'b0;
    pend_resp = -1;
    repeat (40) h_pulse(1'b0);
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_block());
    repeat (3) run_cycle(1'b0, 1'b0, 1'b0);

    // Fill both buffers, then flush with the generator busy for 10 cycles
    auto_resp = 1'b1;
    repeat (31) h_pulse(1'b0);
    repeat (5) run_cycle(1'b0, 1'b0, 1'b0);
    run_cycle(1'b0, 1'b1, 1'b0);
    repeat (10) run_cycle(1'b0, 1'b1, 1'b1);
    repeat (6) run_cycle(1'b0, 1'b0, 1'b0);
    repeat (3) h_pulse(1'b0);

    // H and V rising together: flush only
    run_cycle(1'b1, 1'b1, 1'b0);
    repeat (6) run_cycle(1'b0, 1'b0, 1'b0);
    // Strobe without an outstanding request is ignored
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_block());
    repeat (2) h_pulse(1'b0);

    // Reset mid-line with a request outstanding; late response ignored
    auto_resp = 1'b0;
    pend_resp = -1;
    repeat (31) h_pulse(1'b0);
    repeat (2) run_cycle(1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b1, rand_block());
    repeat (3) run_cycle(1'b0, 1'b0, 1'b1);
    auto_resp = 1'b1;
    repeat (5) run_cycle(1'b0, 1'b0, 1'b0);

    // Random traffic
    hl = 1'b0;
    vl = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) hl = ~hl;
      if ($urandom_range(0, 299) == 0) vl = ~vl;
      else if (vl && $urandom_range(0, 9) == 0) vl = 1'b0;
      resp_lat = $urandom_range(0, 6);
      if (c == 2000) do_reset();
      if ($urandom_range(0, 60) == 0 && pend_resp < 0)
        step(hl, vl, 1'b1, ($urandom_range(0, 3) == 0), rand_block());
      else
        run_cycle(hl, vl, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
